// File: rtl/bcd2bin_seq_pkg.sv
// Shared constants and FSM state type for the sequential BCD-to-binary converter.
package bcd2bin_seq_pkg;

    localparam int unsigned ANCHO       = 8;
    localparam int unsigned NUM_DESPLAZ = 8;
    localparam int unsigned MAX_VALOR   = 255;
    localparam int unsigned DIG_W       = 4;
    localparam int unsigned BCD_W       = 10;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        DESPLAZA = 2'd1,
        FIN      = 2'd2
    } estado_t;

endpackage

// File: rtl/bcd2bin_seq_ajuste_bcd.sv
// Per-digit correction applied after each right shift: digits of 8 or more lose 3.
module ajuste_bcd
    import bcd2bin_seq_pkg::*;
(
    input  logic [DIG_W-1:0] digito,
    output logic [DIG_W-1:0] ajustado_c
);

    assign ajustado_c = (digito >= DIG_W'(8)) ? (digito - DIG_W'(3)) : digito;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential 3-digit BCD to binary converter using right-shift double dabble,
// one shift per clock, with input range validation at request time.
module bcd2bin_seq #(
    parameter int unsigned ANCHO       = bcd2bin_seq_pkg::ANCHO,
    parameter int unsigned NUM_DESPLAZ = bcd2bin_seq_pkg::NUM_DESPLAZ
) (
    input  logic             reloj,
    input  logic             reset,
    input  logic [1:0]       hunds,
    input  logic [3:0]       tens,
    input  logic [3:0]       units,
    input  logic             inicio,
    output logic [ANCHO-1:0] salida,
    output logic             ocupado,
    output logic             listo,
    output logic             error
);

    import bcd2bin_seq_pkg::*;

    localparam int unsigned CNT_W = (NUM_DESPLAZ > 1) ? $clog2(NUM_DESPLAZ) : 1;

    estado_t          estado;
    logic [CNT_W-1:0] cnt;
    logic [BCD_W-1:0] bcd;
    logic [ANCHO-1:0] bin;
    logic             err_pend;

    logic [BCD_W-1:0] valor_c;
    logic             invalido_c;
    logic [BCD_W-1:0] bcd_sh_c;
    logic [ANCHO-1:0] bin_sh_c;
    logic [DIG_W-1:0] dec_aj_c;
    logic [DIG_W-1:0] uni_aj_c;
    logic [BCD_W-1:0] bcd_nxt_c;

    // Range check on the live input digits; only consumed on the accepting edge.
    assign valor_c    = BCD_W'(hunds) * BCD_W'(100) + BCD_W'(tens) * BCD_W'(10) + BCD_W'(units);
    assign invalido_c = (tens > 4'd9) || (units > 4'd9) || (hunds > 2'd2)
                        || (valor_c > BCD_W'(MAX_VALOR));

    assign bcd_sh_c = {1'b0, bcd[BCD_W-1:1]};
    assign bin_sh_c = {bcd[0], bin[ANCHO-1:1]};

    ajuste_bcd u_ajuste_dec (
        .digito     (bcd_sh_c[2*DIG_W-1:DIG_W]),
        .ajustado_c (dec_aj_c)
    );

    ajuste_bcd u_ajuste_uni (
        .digito     (bcd_sh_c[DIG_W-1:0]),
        .ajustado_c (uni_aj_c)
    );

    // The 2-bit hundreds field can never reach 8, so it shifts through uncorrected.
    assign bcd_nxt_c = {bcd_sh_c[BCD_W-1:2*DIG_W], dec_aj_c, uni_aj_c};

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            estado   <= REPOSO;
            cnt      <= '0;
            bcd      <= '0;
            bin      <= '0;
            err_pend <= 1'b0;
            salida   <= '0;
            ocupado  <= 1'b0;
            listo    <= 1'b0;
            error    <= 1'b0;
        end else begin
            listo <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (inicio) begin
                        cnt <= '0;
                        bin <= '0;
                        if (invalido_c) begin
                            err_pend <= 1'b1;
                            bcd      <= '0;
                            estado   <= FIN;
                        end else begin
                            err_pend <= 1'b0;
                            bcd      <= {hunds, tens, units};
                            ocupado  <= 1'b1;
                            estado   <= DESPLAZA;
                        end
                    end
                end
                DESPLAZA: begin
                    bcd <= bcd_nxt_c;
                    bin <= bin_sh_c;
                    if (cnt == CNT_W'(NUM_DESPLAZ - 1)) begin
                        cnt    <= '0;
                        estado <= FIN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FIN: begin
                    salida  <= err_pend ? '0 : bin;
                    error   <= err_pend;
                    listo   <= 1'b1;
                    ocupado <= 1'b0;
                    estado  <= REPOSO;
                end
                default: begin
                    estado <= REPOSO;
                end
            endcase
        end
    end

endmodule

// File: doc/bcd2bin_seq.md
BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 SHALL have parameter ANCHO, default 8, binary result width.
REQ-002 SHALL have parameter NUM_DESPLAZ, default 8, shift iterations per conversion (equals ANCHO).
REQ-003 SHALL have port reloj  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port hunds  input  2  BCD hundreds digit.
REQ-006 SHALL have port tens  input  4  BCD tens digit.
REQ-007 SHALL have port units  input  4  BCD units digit.
REQ-008 SHALL have port inicio  input  1  start request, level-sampled on each rising edge.
REQ-009 SHALL have port salida  output  8  binary result.
REQ-010 SHALL have port ocupado  output  1  high while a conversion is in progress.
REQ-011 SHALL have port listo  output  1  one-cycle completion pulse.
REQ-012 SHALL have port error  output  1  invalid-input flag, valid while listo is high.

Function
REQ-013 SHALL implement an FSM with states REPOSO, DESPLAZA and FIN.
REQ-014 In REPOSO with inicio=1 at edge k, SHALL latch hunds/tens/units and validate them.
REQ-015 Input SHALL be invalid if tens>9, units>9, hunds>2, or the decimal value exceeds 255.
REQ-016 On invalid input at edge k, SHALL go to FIN; at edge k+1, listo=1, error=1 and salida=0.
REQ-017 On valid input at edge k, SHALL go to DESPLAZA, load a 10-bit BCD field plus an 8-bit binary field (zero), set counter=0 and assert ocupado=1.
REQ-018 In DESPLAZA, each edge SHALL shift {bcd,bin} right by one bit, then subtract 3 from every 4-bit BCD digit that is >=8.
REQ-019 After the NUM_DESPLAZ-th shift (edge k+8), SHALL go to FIN.
REQ-020 At edge k+9, SHALL set salida=bin, listo=1, error=0 and ocupado=0, then return to REPOSO.
REQ-021 Total latency SHALL be 9 clocks from inicio sampling to listo for valid input, and 1 clock for invalid input.
REQ-022 listo SHALL be high for exactly one cycle per accepted request.
REQ-023 inicio SHALL be ignored while ocupado=1 or in FIN; no queuing.
REQ-024 inicio held high continuously SHALL start a new conversion on the first REPOSO edge after FIN, giving one result every 10 clocks.
REQ-025 salida SHALL hold its last value until the next completion, and SHALL NOT change during DESPLAZA.
REQ-026 Input digit changes after edge k SHALL NOT affect the result in progress.
REQ-027 The counter SHALL wrap-protect: it never exceeds NUM_DESPLAZ-1 and resets to 0 on each load.

Reset
REQ-028 reset=1 SHALL asynchronously force state=REPOSO, salida=0, ocupado=0, listo=0, error=0, the counter to 0 and the shift register to 0.
REQ-029 reset asserted mid-conversion SHALL abort it with no listo pulse.
REQ-030 On the first edge after reset deasserts, inicio SHALL be honoured normally.

Structure
REQ-031 A shared package SHALL hold the state enum (REPOSO, DESPLAZA, FIN), ANCHO, NUM_DESPLAZ, MAX_VALOR=255 and a BCD digit width constant of 4.
REQ-032 A combinational sub-module ajuste_bcd SHALL be used, instantiated once per BCD digit: 4-bit in/out, subtract 3 if the digit is >=8.
REQ-033 The input-validation comparison SHALL be combinational on the input digits and registered only into the FSM decision.

Verification
REQ-034 hunds=2, tens=5, units=5, inicio pulse at edge k -> listo at k+9, salida=8'd255, error=0.
REQ-035 hunds=1, tens=2, units=8 -> salida=8'd128 after 9 clocks; hunds=0, tens=0, units=0 -> salida=0, error=0.
REQ-036 hunds=2, tens=5, units=6 -> listo and error at k+1, salida=0; tens=4'hA -> same response.
REQ-037 inicio pulse at k+3 during a conversion -> ignored; exactly one listo; salida matches the first operands.
REQ-038 reset asserted at k+4 -> all outputs 0 immediately, no listo; a new request after release returns the correct value.
REQ-039 inicio held high with operands 0,4,2 -> salida=42 with listo pulses every 10 clocks.
